// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, one-cycle bit_done strobe every CLKS_PER_BIT cycles while enabled
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_bit_done
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));

  // Held at zero while disabled so each frame starts on a fresh bit period
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_done = i_en && w_last;
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-serialising UART transmitter: start, 8 data bits LSB-first, optional even parity, stop
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TX,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  input  logic Logic_0,
  input  logic Logic_1,
  output logic Serial_OUT
);
  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_din;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic                 r_serial;
  logic                 w_serial_nxt;
  logic                 w_cnt_en;
  logic                 w_bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_din    = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign w_cnt_en = (r_state != IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_en      (w_cnt_en),
    .o_bit_done(w_bit_done)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (TX) begin
          w_state_nxt   = START;
          w_shift_nxt   = w_din;
          w_bit_idx_nxt = '0;
        end
      end
      START: if (w_bit_done) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
      PARITY: if (w_bit_done) w_state_nxt = STOP;
      STOP:   if (w_bit_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Output level follows the state being entered so the line changes on the same edge
    w_serial_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:  w_serial_nxt = Logic_0;
      DATA:   w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_serial_nxt = r_parity;
`endif
      STOP:   w_serial_nxt = Logic_1;
      default: w_serial_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_serial  <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_serial  <= w_serial_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_parity <= 1'b0;
    end else if (r_state == IDLE && TX) begin
      r_parity <= ^w_din;
    end
  end
`endif

  assign Serial_OUT = r_serial;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level reference model
module tb_uart_tx;
  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx;
  logic [7:0] d;
  logic       serial_out;
  int         vectors = 0;
  int         miscompares = 0;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .TX        (tx),
    .D0        (d[0]),
    .D1        (d[1]),
    .D2        (d[2]),
    .D3        (d[3]),
    .D4        (d[4]),
    .D5        (d[5]),
    .D6        (d[6]),
    .D7        (d[7]),
    .Logic_0   (1'b0),
    .Logic_1   (1'b1),
    .Serial_OUT(serial_out)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return logic'((b >> (idx - 1)) & 8'd1);
    if (idx == NB - 1) return 1'b1;
    ones = 0;
    for (int j = 0; j < 8; j++) if (b[j]) ones++;
    return logic'(ones % 2);
  endfunction

  task automatic expect_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      vectors++;
      if (serial_out !== 1'b1) begin
        miscompares++;
        $display("FAIL %s idle cycle %0d: got %b expected 1", name, i, serial_out);
      end
    end
  endtask

  // Entered at a negedge with TX=1 and D=b already driven; the next posedge starts the frame
  task automatic check_frame(input string name, input logic [7:0] b, input logic [7:0] d_mid,
                             input bit keep_tx);
    logic e;
    @(posedge clk);
    for (int i = 0; i < NB * N; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_tx) tx = 1'b0;
      if (i == N) d = d_mid;
      e = frame_bit(b, i / N);
      vectors++;
      if (serial_out !== e) begin
        miscompares++;
        $display("FAIL %s byte %02h cycle %0d bit %0d: got %b expected %b",
                 name, b, i, i / N, serial_out, e);
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] b;
    b = 8'($urandom);
    rst_n = 1'b0;
    tx = 1'b1;
    d = b;
    expect_idle("reset_hold", 20);
    rst_n = 1'b1;
    check_frame("reset_release", b, 8'($urandom), 1'b0);
    expect_idle("reset_release_tail", 3);
  endtask

  task automatic test_single_byte;
    d = 8'hA5;
    tx = 1'b1;
    check_frame("single_a5", 8'hA5, 8'hA5, 1'b0);
    expect_idle("single_a5_tail", 4);
  endtask

  task automatic test_data_change;
    d = 8'h00;
    tx = 1'b1;
    check_frame("data_change", 8'h00, 8'hFF, 1'b0);
    expect_idle("data_change_tail", 2);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      d = b;
      tx = 1'b1;
      check_frame("data_change_rand", b, ~b, 1'b0);
      expect_idle("data_change_rand_tail", 1);
    end
  endtask

  task automatic test_back_to_back;
    d = 8'h55;
    tx = 1'b1;
    check_frame("b2b_first", 8'h55, 8'h0F, 1'b1);
    expect_idle("b2b_gap", 1);
    check_frame("b2b_second", 8'h0F, 8'h0F, 1'b0);
    expect_idle("b2b_tail", 3);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'($urandom) & 8'hF7;
    d = b;
    tx = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4 * N + 1; i++) begin
      @(negedge clk);
      if (i == 0) tx = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (serial_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: got %b expected 1", serial_out);
    end
    expect_idle("reset_mid_hold", 3);
    rst_n = 1'b1;
    expect_idle("reset_mid_abandoned", NB * N);
    b = 8'($urandom);
    d = b;
    tx = 1'b1;
    check_frame("reset_mid_fresh", b, 8'($urandom), 1'b0);
    expect_idle("reset_mid_tail", 1);
  endtask

  task automatic test_parity_bytes;
    d = 8'h07;
    tx = 1'b1;
    check_frame("parity_07", 8'h07, 8'h07, 1'b0);
    expect_idle("parity_07_tail", 1);
    d = 8'h03;
    tx = 1'b1;
    check_frame("parity_03", 8'h03, 8'h03, 1'b0);
    expect_idle("parity_03_tail", 1);
  endtask

  task automatic test_random_frames;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] b;
      expect_idle("random_gap", int'($urandom_range(0, 3)));
      b = 8'($urandom);
      d = b;
      tx = 1'b1;
      check_frame("random", b, 8'($urandom), 1'b0);
      expect_idle("random_tail", 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx = 1'b0;
    d = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_data_change();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity_bytes();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
